clz_stream_engine: RTL and testbench

CLZ_STREAM_ENGINE -- requirements
Module: clz_stream_engine

---
 rtl/clz_stream_pkg.sv | 8 +
 rtl/clz_unit.sv | 34 +++
 rtl/clz_stream_engine.sv | 90 +++++++++
 tb/tb_clz_stream_engine.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clz_stream_pkg.sv
// clz_stream_pkg: shared enums and default parameters for the CLZ stream engine
package clz_stream_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 16;
  localparam int LEN_W_DEF = 16;
  typedef enum logic [1:0] {CLZ, CTZ, POPCNT, RSVD} mode_e;
  typedef enum logic [2:0] {IDLE, RD, CAP, WR, FIN} state_e;
endpackage

// File: rtl/clz_unit.sv
// clz_unit: combinational CLZ/CTZ (and POPCNT when CLZ_STREAM_POPCNT_EN is defined)
module clz_unit
  import clz_stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] word,
  input  mode_e             mode,
  output logic [DATA_W-1:0] result
);
  localparam int CW = $clog2(DATA_W) + 1;
  logic [DATA_W-1:0] rev;
  logic [DATA_W-1:0] src;
  logic [CW-1:0] lz;
  for (genvar i = 0; i < DATA_W; i++) begin : g_rev
    assign rev[i] = word[DATA_W-1-i];
  end
  // trailing zeros are the leading zeros of the mirrored word
  assign src = (mode == CTZ) ? rev : word;
  always_comb begin
    lz = CW'(DATA_W);
    for (int k = 0; k < DATA_W; k++) lz = src[k] ? CW'(DATA_W - 1 - k) : lz;
  end
`ifdef CLZ_STREAM_POPCNT_EN
  logic [CW-1:0] pc;
  always_comb begin
    pc = '0;
    for (int k = 0; k < DATA_W; k++) pc = pc + CW'(word[k]);
  end
  assign result = DATA_W'((mode == POPCNT) ? pc : lz);
`else
  assign result = DATA_W'(lz);
`endif
endmodule

// File: rtl/clz_stream_engine.sv
// clz_stream_engine: in-place CLZ/CTZ/POPCNT over a memory array, 3 cycles per element
// Optional popcount mode enabled by defining CLZ_STREAM_POPCNT_EN.
module clz_stream_engine
  import clz_stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] arr_1,
  input  logic [LEN_W-1:0]  length,
  input  logic [1:0]        mode,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data
);
  state_e state;
  mode_e mode_q;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0] cnt;
  logic [DATA_W-1:0] result;
  clz_unit #(.DATA_W(DATA_W)) u_unit (
    .word  (mem_rd_data),
    .mode  (mode_q),
    .result(result)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mode_q      <= CLZ;
      addr        <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            addr        <= arr_1;
            cnt         <= length;
            mode_q      <= mode_e'(mode);
            busy        <= 1'b1;
            state       <= (length == '0) ? FIN : RD;
            mem_rd_en   <= (length != '0);
            mem_rd_addr <= arr_1;
          end
        end
        RD: begin
          mem_rd_en <= 1'b0;
          state     <= CAP;
        end
        // read data arrives this cycle; the result is captured straight into the write port
        CAP: begin
          mem_wr_data <= result;
          mem_wr_en   <= 1'b1;
          mem_wr_addr <= addr;
          state       <= WR;
        end
        WR: begin
          mem_wr_en   <= 1'b0;
          addr        <= addr + 1'b1;
          cnt         <= cnt - 1'b1;
          mem_rd_addr <= addr + 1'b1;
          mem_rd_en   <= (cnt != LEN_W'(1));
          state       <= (cnt != LEN_W'(1)) ? RD : FIN;
        end
        FIN: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_clz_stream_engine.sv
// tb_clz_stream_engine: scoreboard bench for clz_stream_engine (honours CLZ_STREAM_POPCNT_EN)
module tb_clz_stream_engine;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int LW = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [AW-1:0] arr_1 = '0;
  logic [LW-1:0] length = '0;
  logic [1:0] mode = '0;
  logic busy, done, mem_rd_en, mem_wr_en;
  logic [AW-1:0] mem_rd_addr, mem_wr_addr;
  logic [DW-1:0] mem_rd_data, mem_wr_data;
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] wr_log[$];
  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;

  clz_stream_engine #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .arr_1(arr_1), .length(length), .mode(mode),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rd_data <= mem[mem_rd_addr];
      rd_cnt++;
    end
    if (mem_wr_en) begin
      mem[mem_wr_addr] <= mem_wr_data;
      wr_log.push_back({mem_wr_addr, mem_wr_data});
    end
  end

  function automatic logic [DW-1:0] model(input logic [DW-1:0] w, input logic [1:0] m);
    int n = 0;
    if (m == 2'd1) while (n < DW && !w[n]) n++;
`ifdef CLZ_STREAM_POPCNT_EN
    else if (m == 2'd2) for (int k = 0; k < DW; k++) n += int'(w[k]);
`endif
    else while (n < DW && !w[DW-1-n]) n++;
    return DW'(n);
  endfunction

  task automatic launch(input logic [AW-1:0] a, input int n, input logic [1:0] m, output int cyc);
    for (int i = 0; i < n; i++) exp_q.push_back({AW'(a + i), model(mem[AW'(a + i)], m)});
    arr_1 = a;
    length = LW'(n);
    mode = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    arr_1 = 16'h5555;
    length = 16'd7;
    mode = ~m;
    cyc = 1;
    while (!done && cyc < 3 * n + 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    length = 16'd2;
    arr_1 = 16'h0100;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, mem_rd_en, mem_wr_en} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 0000", {busy, done, mem_rd_en, mem_wr_en});
    end
    checks++;
    if ({mem_rd_addr, mem_wr_addr, mem_wr_data} !== '0) begin
      errors++;
      $display("FAIL reset_bus got %h/%h/%h want 0", mem_rd_addr, mem_wr_addr, mem_wr_data);
    end
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rd_cnt !== 0) begin
      errors++;
      $display("FAIL reset_start_priority got busy=%b rd=%0d want busy=0 rd=0", busy, rd_cnt);
    end
  endtask

  task automatic test_clz();
    int cyc;
    logic [AW+DW-1:0] e, a;
    int r0 = rd_cnt;
    mem[16'h10] = 32'h0000_0001;
    mem[16'h11] = 32'h8000_0000;
    mem[16'h12] = 32'h0000_0000;
    launch(16'h10, 3, 2'd0, cyc);
    checks++;
    if (cyc !== 11) begin errors++; $display("FAIL clz_latency got %0d want 11", cyc); end
    checks++;
    if (rd_cnt - r0 !== 3) begin errors++; $display("FAIL clz_reads got %0d want 3", rd_cnt - r0); end
    checks++;
    if ({mem[16'h10], mem[16'h11], mem[16'h12]} !== {32'd31, 32'd0, 32'd32}) begin
      errors++;
      $display("FAIL clz_mem got %0d,%0d,%0d want 31,0,32", mem[16'h10], mem[16'h11], mem[16'h12]);
    end
    checks++;
    if (wr_log.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL clz_wr_count got %0d want %0d", wr_log.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && wr_log.size() > 0) begin
      e = exp_q.pop_front();
      a = wr_log.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL clz_write got %h want %h", a, e); end
    end
    exp_q.delete();
    wr_log.delete();
  endtask

  task automatic test_ctz();
    int cyc;
    logic [AW+DW-1:0] e, a;
    mem[16'h20] = 32'h0000_0008;
    mem[16'h21] = 32'h0000_0000;
    launch(16'h20, 2, 2'd1, cyc);
    checks++;
    if (cyc !== 8) begin errors++; $display("FAIL ctz_latency got %0d want 8", cyc); end
    checks++;
    if (wr_log.size() !== 2) begin errors++; $display("FAIL ctz_wr_count got %0d want 2", wr_log.size()); end
    checks++;
    if ({mem[16'h20], mem[16'h21]} !== {32'd3, 32'd32}) begin
      errors++;
      $display("FAIL ctz_mem got %0d,%0d want 3,32", mem[16'h20], mem[16'h21]);
    end
    while (exp_q.size() > 0 && wr_log.size() > 0) begin
      e = exp_q.pop_front();
      a = wr_log.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL ctz_write got %h want %h", a, e); end
    end
    exp_q.delete();
    wr_log.delete();
  endtask

  task automatic test_zero_len();
    int cyc;
    int r0 = rd_cnt;
    launch(16'h30, 0, 2'd0, cyc);
    checks++;
    if (cyc !== 2) begin errors++; $display("FAIL zero_latency got %0d want 2", cyc); end
    checks++;
    if (rd_cnt !== r0 || wr_log.size() !== 0) begin
      errors++;
      $display("FAIL zero_no_access got rd=%0d wr=%0d want 0/0", rd_cnt - r0, wr_log.size());
    end
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin errors++; $display("FAIL zero_idle got %b want 00", {busy, done}); end
    exp_q.delete();
    wr_log.delete();
  endtask

  task automatic test_wrap();
    int cyc;
    logic [AW+DW-1:0] e, a;
    mem[16'hFFFF] = 32'h0001_0000;
    mem[16'h0000] = 32'h0000_0100;
    launch(16'hFFFF, 2, 2'd0, cyc);
    checks++;
    if (wr_log.size() !== 2) begin errors++; $display("FAIL wrap_wr_count got %0d want 2", wr_log.size()); end
    checks++;
    if ({mem[16'hFFFF], mem[16'h0000]} !== {32'd15, 32'd23}) begin
      errors++;
      $display("FAIL wrap_mem got %0d,%0d want 15,23", mem[16'hFFFF], mem[16'h0000]);
    end
    while (exp_q.size() > 0 && wr_log.size() > 0) begin
      e = exp_q.pop_front();
      a = wr_log.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL wrap_write got %h want %h", a, e); end
    end
    exp_q.delete();
    wr_log.delete();
  endtask

  task automatic test_popcnt();
    int cyc;
    logic [DW-1:0] want;
`ifdef CLZ_STREAM_POPCNT_EN
    want = 32'd16;
`else
    want = 32'd0;
`endif
    mem[16'h50] = 32'hF0F0_F0F0;
    launch(16'h50, 1, 2'd2, cyc);
    checks++;
    if (mem[16'h50] !== want) begin errors++; $display("FAIL popcnt got %0d want %0d", mem[16'h50], want); end
    checks++;
    if (wr_log.size() !== 1 || wr_log[0] !== exp_q[0]) begin
      errors++;
      $display("FAIL popcnt_write got %0d entries want 1 entry %h", wr_log.size(), exp_q[0]);
    end
    exp_q.delete();
    wr_log.delete();
  endtask

  task automatic test_abort();
    int cyc;
    int waited = 0;
    bit saw_done = 0;
    logic [AW+DW-1:0] e, a;
    for (int i = 0; i < 4; i++) mem[16'h60 + i] = 32'h0000_0100 << i;
    arr_1 = 16'h60;
    length = 16'd4;
    mode = 2'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!mem_wr_en && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (mem_wr_en !== 1'b1) begin errors++; $display("FAIL abort_wr_wait got %b want 1", mem_wr_en); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, done, mem_wr_en} !== 3'b000) begin
      errors++;
      $display("FAIL abort_state got %b want 000", {busy, done, mem_wr_en});
    end
    repeat (15) begin
      @(negedge clk);
      saw_done |= done;
    end
    checks++;
    if (wr_log.size() !== 1 || saw_done) begin
      errors++;
      $display("FAIL abort_writes got %0d done=%b want 1 done=0", wr_log.size(), saw_done);
    end
    checks++;
    if ({mem[16'h60], mem[16'h61]} !== {32'd23, 32'h0000_0200}) begin
      errors++;
      $display("FAIL abort_mem got %h,%h want 17,200", mem[16'h60], mem[16'h61]);
    end
    wr_log.delete();
    mem[16'h70] = 32'h0000_00FF;
    launch(16'h70, 1, 2'd0, cyc);
    checks++;
    if (cyc !== 5) begin errors++; $display("FAIL abort_restart_latency got %0d want 5", cyc); end
    while (exp_q.size() > 0 && wr_log.size() > 0) begin
      e = exp_q.pop_front();
      a = wr_log.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL abort_restart_write got %h want %h", a, e); end
    end
    exp_q.delete();
    wr_log.delete();
  endtask

  task automatic test_back_to_back();
    int cyc;
    int want_n;
    logic [AW+DW-1:0] e, a;
    logic [1:0] modes [3] = '{2'd0, 2'd1, 2'd3};
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < 5; i++) mem[16'h200 + 16 * j + i] = $urandom >> $urandom_range(0, 31);
      launch(AW'(16'h200 + 16 * j), 5, modes[j], cyc);
      checks++;
      if (cyc !== 17) begin errors++; $display("FAIL b2b_latency job %0d got %0d want 17", j, cyc); end
    end
    want_n = exp_q.size();
    checks++;
    if (wr_log.size() !== want_n) begin
      errors++;
      $display("FAIL b2b_wr_count got %0d want %0d", wr_log.size(), want_n);
    end
    while (exp_q.size() > 0 && wr_log.size() > 0) begin
      e = exp_q.pop_front();
      a = wr_log.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL b2b_write got %h want %h", a, e); end
    end
    exp_q.delete();
    wr_log.delete();
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    test_reset();
    test_clz();
    test_ctz();
    test_zero_len();
    test_wrap();
    test_popcnt();
    test_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
